unidade_ponto_flt: RTL and testbench

- Multi-cycle IEEE-754 single-precision floating-point unit for the RISC-V processor's FP datapath.
- Computes a*b when multiplicando=1 and a+b when multiplicando=0.
- A start/finish handshake sequences each operation. The result is held on s until the next operation completes.

---
 rtl/unidade_ponto_flt.sv | 153 +++++++++++++++
 tb/tb_unidade_ponto_flt.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/unidade_ponto_flt.sv
// unidade_ponto_flt: multi-cycle binary32 multiply/add unit (IDLE->UNPACK->COMPUTE->NORM->ROUND) with start/finish handshake
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   a, b          binary32 operands, latched when start is seen in IDLE
//   start         launch request
//   multiplicando 1=a*b, 0=a+b
//   s             registered result, held until the next operation completes
//   finish        one-cycle completion pulse, 4 edges after the launch edge
//   flags         {invalid, overflow, underflow, inexact}, only when UPF_FLAGS_EN is defined
module unidade_ponto_flt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  input  logic        multiplicando,
  output logic [31:0] s,
  output logic        finish
`ifdef UPF_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);
  localparam logic [2:0] IDLE = 3'd0, UNPACK = 3'd1, COMPUTE = 3'd2, NORM = 3'd3, ROUND = 3'd4;
  logic [2:0] state;
  logic [31:0] ra, rb, sv;
  logic rop, sp, sinv, sa, sb, cs;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  logic signed [9:0] ce, ne;
  logic [48:0] cm;
  logic [47:0] nm;
  logic [7:0] ea_w, eb_w;
  logic za, zb, ia, ib, na, nb, u_nan, u_sp;
  logic [23:0] ma_w, mb_w;
  logic [31:0] u_val;
  assign ea_w = ra[30:23];
  assign eb_w = rb[30:23];
  assign za = ea_w == 8'd0;
  assign zb = eb_w == 8'd0;
  assign ia = &ea_w && ra[22:0] == 23'd0;
  assign ib = &eb_w && rb[22:0] == 23'd0;
  assign na = &ea_w && |ra[22:0];
  assign nb = &eb_w && |rb[22:0];
  // denormals are treated as zero by dropping their mantissa entirely
  assign ma_w = za ? 24'd0 : {1'b1, ra[22:0]};
  assign mb_w = zb ? 24'd0 : {1'b1, rb[22:0]};
  assign u_nan = na | nb | (rop ? (ia & zb) | (za & ib) : ia & ib & (ra[31] != rb[31]));
  assign u_sp = u_nan | ia | ib | za | zb;
  always_comb begin
    u_val = u_nan ? 32'h7FC0_0000 :
            rop ? ((ia | ib) ? {ra[31] ^ rb[31], 8'hFF, 23'd0} : {ra[31] ^ rb[31], 31'd0}) :
            ia ? {ra[31], 8'hFF, 23'd0} :
            ib ? {rb[31], 8'hFF, 23'd0} :
            (za & zb) ? {ra[31] & rb[31], 31'd0} :
            za ? rb : ra;
  end
  logic a_big;
  logic [23:0] ml, ms;
  logic [7:0] el, d;
  logic [95:0] t;
  logic sticky;
  logic [48:0] lx, sx, sum;
  logic [47:0] prod;
  logic signed [9:0] emul;
  // the mantissa datapath places the hidden bit at 47, with bit 48 catching carries
  assign a_big = {ea, ma} >= {eb, mb};
  assign ml = a_big ? ma : mb;
  assign ms = a_big ? mb : ma;
  assign el = a_big ? ea : eb;
  assign d = el - (a_big ? eb : ea);
  assign t = {ms, 72'd0} >> d;
  // anything shifted below the 48-bit window is jammed into the lsb as sticky
  assign sticky = (|t[47:0]) | (d > 8'd71);
  assign sx = {1'b0, t[95:49], t[48] | sticky};
  assign lx = {1'b0, ml, 24'd0};
  assign sum = (sa == sb) ? lx + sx : lx - sx;
  assign prod = {24'd0, ma} * {24'd0, mb};
  assign emul = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
  logic [5:0] pos, lz;
  logic [47:0] nm_w;
  logic signed [9:0] ne_w;
  always_comb begin
    pos = 6'd0;
    for (int i = 0; i < 49; i++) if (cm[i]) pos = 6'(i);
  end
  assign lz = 6'd47 - pos;
  assign nm_w = cm[48] ? {cm[48:2], cm[1] | cm[0]} : cm[47:0] << lz;
  assign ne_w = cm[48] ? ce + 10'sd1 : ce - $signed({4'd0, lz});
  logic g, r, st, up, of, uf, inex;
  logic [24:0] rm;
  logic signed [9:0] fe;
  logic [31:0] res;
  assign g = nm[23];
  assign r = nm[22];
  assign st = |nm[21:0];
  assign up = g & (r | st | nm[24]);
  assign rm = {1'b0, nm[47:24]} + {24'd0, up};
  assign fe = ne + $signed({9'd0, rm[24]});
  assign of = nm != 48'd0 && fe > 10'sd254;
  assign uf = nm != 48'd0 && fe < 10'sd1;
  assign inex = g | r | st | of | uf;
  // exact cancellation lands here as an all-zero mantissa and yields +0
  always_comb begin
    res = nm == 48'd0 ? 32'd0 :
          of ? {cs, 8'hFF, 23'd0} :
          uf ? {cs, 31'd0} : {cs, fe[7:0], rm[22:0]};
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ra <= a;
      rb <= b;
      rop <= multiplicando;
    end
    if (state == UNPACK) begin
      sp <= u_sp;
      sv <= u_val;
      sinv <= u_nan;
      sa <= ra[31];
      sb <= rb[31];
      ea <= ea_w;
      eb <= eb_w;
      ma <= ma_w;
      mb <= mb_w;
    end
    if (state == COMPUTE) begin
      cs <= rop ? sa ^ sb : (a_big ? sa : sb);
      ce <= rop ? emul : $signed({2'b0, el});
      cm <= rop ? {prod, 1'b0} : sum;
    end
    if (state == NORM) begin
      nm <= nm_w;
      ne <= ne_w;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s <= 32'd0;
      finish <= 1'b0;
`ifdef UPF_FLAGS_EN
      flags <= 4'd0;
`endif
    end else begin
      finish <= state == ROUND;
      if (state == ROUND) s <= sp ? sv : res;
`ifdef UPF_FLAGS_EN
      if (state == ROUND) flags <= sp ? {sinv, 3'b000} : {1'b0, of, uf, inex};
`endif
      state <= state == IDLE ? (start ? UNPACK : IDLE) : state == ROUND ? IDLE : state + 3'd1;
    end
  end
endmodule

// File: tb/tb_unidade_ponto_flt.sv
// tb_unidade_ponto_flt: scoreboard bench for unidade_ponto_flt with directed binary32 vectors
module tb_unidade_ponto_flt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic start = 1'b0, multiplicando = 1'b0;
  logic [31:0] s;
  logic finish;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int cyc_q[$];
  unidade_ponto_flt dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start),
    .multiplicando(multiplicando), .s(s), .finish(finish)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (finish) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_finish s=%h at cycle %0d, nothing expected", s, cyc);
      end else begin
        logic [31:0] e;
        int l;
        e = exp_q.pop_front();
        l = cyc_q.pop_front();
        checks++;
        if (s !== e) begin
          errors++;
          $display("FAIL result got=%h want=%h", s, e);
        end
        checks++;
        if (cyc - l != 4) begin
          errors++;
          $display("FAIL latency got=%0d want=4", cyc - l);
        end
      end
    end
  end
  task automatic wait_done();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d want=0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask
  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic m, input logic [31:0] e);
    @(negedge clk);
    a = x;
    b = y;
    multiplicando = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    start = 1'b0;
    a = ~x;
    b = ~y;
    multiplicando = ~m;
    wait_done();
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_s", s, 32'd0);
    chk("reset_finish", {31'd0, finish}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_finish", {31'd0, finish}, 32'd0);
    end
    @(negedge clk);
    a = 32'h3E99999A;
    b = 32'h3E4CCCCD;
    multiplicando = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(32'h3D75C290);
      cyc_q.push_back(cyc);
      if (k < 2) repeat (4) @(posedge clk);
    end
    start = 1'b0;
    wait_done();
    op(32'h3E99999A, 32'h3E4CCCCD, 1'b0, 32'h3F000000);
    repeat (3) @(negedge clk);
    chk("hold_s", s, 32'h3F000000);
    op(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);
    op(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000);
    op(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000);
    op(32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000);
    op(32'h00800000, 32'h3F000000, 1'b1, 32'h00000000);
    op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    op(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000);
    op(32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000);
    op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000);
    op(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000);
    op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
    op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    op(32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000);
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h40000000;
    multiplicando = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_s", s, 32'd0);
    chk("midreset_finish", {31'd0, finish}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("after_abort_s", s, 32'd0);
    op(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
